alu_seq: RTL
============

# alu_seq

Registered, handshaked successor to the combinational datapath ALU, parametrised in width. It adds a stored NZCV flag register, multi-word add/subtract with carry chaining, single-bit shifts and an optional iterative multiplier. It sits between the register-file read stage and the write-back stage. Operands are accepted over a valid/ready handshake, and results are held until write-back consumes them.

## Interface
- `N`, default 16: operand/result width in bits, N ≥ 2.
- `clk` input 1: the only clock, rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands and opcode are valid this cycle.
- `in_ready` output 1: block can accept a new operation. It is high only in IDLE and is 0 while `rst` is high.
- `a` input N: operand A.
- `b` input N: operand B.
- `op` input 4: opcode, decoded below.
- `out_valid` output 1: `result` and the flags are valid. Held high until consumed.
- `out_ready` input 1: downstream consumes the result.
- `result` output N: registered result.
- `n_flag`, `c_flag`, `v_flag`, `z_flag` output 1 each: registered negative, carry, overflow and zero flags.

## Operation
- Opcodes with `op[3]`=0 (arithmetic and logic):
  - 0000: a+b
  - 0001: a−b
  - 0010: a+1
  - 0011: a−1
  - 0100: a&b
  - 0101: a|b
  - 0110: a^b
  - 0111: ~a
- Opcodes with `op[3]`=1:
  - 1000 ADC: a+b+C
  - 1001 SBC: a+~b+C
  - 1010 SHL: a<<1, LSB filled with 0
  - 1011 SHR: logical a>>1
  - 1100 MUL: low N bits of unsigned a*b
  - 1101–1111: reserved
- C in ADC/SBC is the stored `c_flag`.
- Subtraction is computed as a+~b+1. C is the carry out, so C=1 means no borrow. DEC is a+~1+1, so C=(a≠0).
- Operands and opcode are latched on accept. Later changes to the inputs do not affect an operation in flight.
- Flag update rules, applied when the result is registered:
  - N = result[N−1] for all ops. Z = (result==0) for all ops.
  - Arithmetic ops (0000–0011, 1000, 1001): C = carry out; V = signed overflow of the addition actually performed.
  - Logic ops: C unchanged, V=0.
  - SHL: C=a[N−1], V=0. SHR: C=a[0], V=0.
  - MUL: C unchanged, V = (upper N bits of the 2N-bit product ≠ 0).
  - Reserved: result=0, N=0, Z=1, C and V unchanged.
- State machine:
  - IDLE → DONE on accept of any non-MUL op.
  - IDLE → BUSY on accept of MUL.
  - BUSY: shift-add over N cycles, with a cycle counter from 0 to N−1. Moves to DONE when the counter reaches N−1.
  - DONE → IDLE when `out_ready`=1.
- `result` and the flags hold their values in all states except the cycle that enters DONE.

## Timing
- Reset values: state IDLE, `result`=0, all flags 0, `out_valid`=0. `in_ready` is 1 from the first cycle after `rst` deasserts.
- Accept occurs on a rising edge where `in_valid`&&`in_ready`.
- Latency, with the accept edge as cycle 0:
  - Non-MUL op: `out_valid` high from cycle 1.
  - MUL: `out_valid` high from cycle N+1 (cycle 17 for N=16).
- `in_ready`=0 throughout BUSY and DONE, and `in_valid` is ignored there. There is no same-cycle retire-and-accept, so peak throughput is one op per 2 cycles.
- `out_valid` stays high and `result` stays stable while `out_ready`=0. `out_ready` is ignored when `out_valid`=0.
- Reset mid-operation (BUSY or DONE): the operation is aborted, no result is produced, and all registers return to their reset values.
- ADC/SBC use the C value stored after the previous retired op. Retirement is serialised, so there is no hazard.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - Opcode 1100 is MUL.
  - BUSY state, the cycle counter and the 2N-bit accumulator are instantiated.
- `ALU_SEQ_MUL_EN` undefined:
  - 1100 is reserved: 1-cycle latency, result=0, Z=1.
  - No BUSY state or multiplier hardware is generated.

## Test plan
- ADD overflow, N=16: add 0x7FFF+0x0001 → `result`=0x8000, N=1, V=1, C=0, Z=0. `out_valid` rises at cycle 1.
- Carry chain: add 0xFFFF+0x0001 → 0x0000, C=1, Z=1. Then ADC 0x0000+0x0000 → 0x0001, C=0. Separately, SUB 0x0005−0x0005 → 0x0000, Z=1, C=1, V=0.
- Shifts: SHL 0x8001 → 0x0002, C=1. SHR 0x0003 → 0x0001, C=1. AND 0x00F0&0x0F0F → 0x0000, Z=1, C unchanged.
- MUL (`ALU_SEQ_MUL_EN` defined): 0x0003*0x0005 → 0x000F, V=0, `out_valid` at cycle 17. 0x0100*0x0100 → 0x0000, Z=1, V=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result`, flags and `out_valid` are stable, `in_ready`=0, and a new op driven on `in_valid` is not accepted.
- Reset mid-MUL: assert `rst` at BUSY cycle 4 → next cycle `out_valid`=0, flags=0, `result`=0. `in_ready`=1 one cycle after `rst` deasserts, and no stale result appears.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a stored NZCV flag register,
// carry-chained add/subtract, single-bit shifts and an optional iterative
// shift-add multiplier.
//
// Build option: define ALU_SEQ_MUL_EN to make opcode 1100 an N-cycle
// multiply. When it is undefined, 1100 is a reserved opcode and no
// multiplier hardware is built.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a/b/op valid this cycle
//   in_ready   ready to accept (IDLE only, low while rst is high)
//   a, b       operands, N bits
//   op         4-bit opcode
//   out_valid  result and flags valid, held until out_ready
//   out_ready  downstream consumes the result
//   result     registered N-bit result
//   n_flag, c_flag, v_flag, z_flag  registered NZCV flags
module alu_seq #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         n_flag,
   output logic         c_flag,
   output logic         v_flag,
   output logic         z_flag
);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam int unsigned CW = $clog2(N);
   logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;
`else
   typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

   state_t       state_q, state_d;
   logic [N-1:0] result_q, result_d;
   logic         n_q, n_d, c_q, c_d, v_q, v_d, z_q, z_d;

   // Single-cycle datapath
   logic [N:0]   sum;
   logic [N-1:0] addend;
   logic         cin;
   logic [N-1:0] alu_res;
   logic         alu_c, alu_v;

   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (op)
         4'b0000: addend = b;
         4'b0001: begin addend = ~b; cin = 1'b1; end
         4'b0010: cin = 1'b1;
         // DEC as a + ~1 + 1, so carry out means a was non-zero
         4'b0011: begin addend = ~{{(N-1){1'b0}}, 1'b1}; cin = 1'b1; end
         4'b1000: begin addend = b;  cin = c_q; end
         4'b1001: begin addend = ~b; cin = c_q; end
         default: ;
      endcase
      sum = {1'b0, a} + {1'b0, addend} + {{N{1'b0}}, cin};

      alu_res = '0;
      alu_c   = c_q;
      alu_v   = 1'b0;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001: begin
            alu_res = sum[N-1:0];
            alu_c   = sum[N];
            alu_v   = (a[N-1] == addend[N-1]) && (sum[N-1] != a[N-1]);
         end
         4'b0100: alu_res = a & b;
         4'b0101: alu_res = a | b;
         4'b0110: alu_res = a ^ b;
         4'b0111: alu_res = ~a;
         4'b1010: begin alu_res = {a[N-2:0], 1'b0}; alu_c = a[N-1]; end
         4'b1011: begin alu_res = {1'b0, a[N-1:1]}; alu_c = a[0];   end
         // reserved: zero result, carry and overflow left as they were
         default: alu_v = v_q;
      endcase
   end

   // Next-state and register-update logic
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      n_d      = n_q;
      c_d      = c_q;
      v_d      = v_q;
      z_d      = z_q;
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      prod     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
               if (op == 4'b1100) begin
                  state_d  = BUSY;
                  acc_d    = '0;
                  mcand_d  = {{N{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
               end else
`endif
               begin
                  state_d  = DONE;
                  result_d = alu_res;
                  n_d      = alu_res[N-1];
                  z_d      = (alu_res == '0);
                  c_d      = alu_c;
                  v_d      = alu_v;
               end
            end
         end
`ifdef ALU_SEQ_MUL_EN
         // One partial product per cycle; multiplier consumed LSB first
         BUSY: begin
            acc_d    = prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d  = DONE;
               result_d = prod[N-1:0];
               n_d      = prod[N-1];
               z_d      = (prod[N-1:0] == '0);
               v_d      = |prod[2*N-1:N];
            end
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         n_q      <= n_d;
         c_q      <= c_d;
         v_q      <= v_d;
         z_q      <= z_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign n_flag    = n_q;
   assign c_flag    = c_q;
   assign v_flag    = v_q;
   assign z_flag    = z_q;

endmodule
